// File: rtl/spike_rate_encoder.sv
// -----------------------------------------------------------------------------
// spike_rate_encoder
//
// Front end of the SNN. It buffers one frame of N_CH pixel intensities that
// arrive serially on a valid/ready stream. It then replays that frame once per
// network tick as N_CH rate-coded spike trains, for N_STEPS timesteps.
//
// Ports:
//   clk         in   1       clock, all logic on posedge
//   reset       in   1       synchronous, active-high, clears all state
//   pix_valid   in   1       pixel beat valid
//   pix_ready   out  1       encoder can accept a pixel beat (LOAD state)
//   pix_data    in   PIX_W   pixel intensity, channel order 0..N_CH-1
//   tick        in   1       advance one network timestep (honoured in RUN only)
//   syn         out  N_CH    spike vector, nonzero only while syn_valid=1
//   syn_valid   out  1       one-cycle strobe: syn carries this timestep's spikes
//   busy        out  1       1 while in RUN
//   frame_done  out  1       pulse coincident with the last syn_valid of a frame
//
// Build option:
//   ENC_DETERMINISTIC_EN  When this macro is defined, the LFSR comparator is
//                         replaced by a per-channel carry accumulator. With it,
//                         each channel fires exactly
//                         floor(N_STEPS*pix/2^PIX_W) times per frame.
//                         When the macro is undefined (the default), the
//                         stochastic LFSR rule is used.
// -----------------------------------------------------------------------------
module spike_rate_encoder #(
   parameter int          N_CH      = 16,
   parameter int          PIX_W     = 8,
   parameter int          N_STEPS   = 32,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             tick,
   output logic [N_CH-1:0]  syn,
   output logic             syn_valid,
   output logic             busy,
   output logic             frame_done
);

   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int STEP_W = $clog2(N_STEPS + 1);
   localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_reg, state_next;
   logic [CH_W-1:0]     ch_idx_reg;
   logic [STEP_W-1:0]   step_cnt_reg;
   logic [N_CH-1:0]     syn_reg;
   logic                syn_valid_reg;
   logic                frame_done_reg;
   logic [N_CH-1:0]     spike_vec;

   logic                beat_accept;   // pixel beat written this cycle
   logic                load_done;     // last beat of the frame accepted
   logic                run_tick;      // tick honoured in RUN
   logic                frame_end;     // tick on the final timestep

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_LOAD;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pix_ready   = 1'b0;
      busy        = 1'b0;
      beat_accept = 1'b0;
      load_done   = 1'b0;
      run_tick    = 1'b0;
      frame_end   = 1'b0;
      case (state_reg)
         ST_LOAD: begin
            pix_ready = 1'b1;
            if (pix_valid) begin
               beat_accept = 1'b1;
               if (ch_idx_reg == LAST_CH) begin
                  load_done  = 1'b1;
                  state_next = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (tick) begin
               run_tick = 1'b1;
               if (step_cnt_reg == LAST_STEP) begin
                  frame_end  = 1'b1;
                  state_next = ST_LOAD;
               end
            end
         end
         default: state_next = ST_LOAD;
      endcase
   end

   // ------------------------------------------------- counters and outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         ch_idx_reg     <= '0;
         step_cnt_reg   <= '0;
         syn_reg        <= '0;
         syn_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         if (beat_accept) begin
            ch_idx_reg <= load_done ? '0 : ch_idx_reg + CH_W'(1);
         end
         if (load_done) begin
            step_cnt_reg <= '0;
         end else if (run_tick) begin
            step_cnt_reg <= frame_end ? '0 : step_cnt_reg + STEP_W'(1);
         end
         // Downstream neurons integrate syn every clock, so syn is cleared
         // in every cycle that is not a strobe.
         syn_reg        <= run_tick ? spike_vec : '0;
         syn_valid_reg  <= run_tick;
         frame_done_reg <= frame_end;
      end
   end

   assign syn        = syn_reg;
   assign syn_valid  = syn_valid_reg;
   assign frame_done = frame_done_reg;

`ifndef ENC_DETERMINISTIC_EN
   // ------------------------------------------------ shared Galois LFSR
   // The LFSR advances once per honoured tick, after its value has been used.
   // It is reseeded only by reset, so successive frames see a continuing
   // sequence.
   localparam logic [15:0] RND_MASK = 16'((32'd1 << PIX_W) - 32'd1);

   logic [15:0] lfsr_reg;
   logic [15:0] lfsr_next;

   assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_reg <= LFSR_SEED;
      end else if (run_tick) begin
         lfsr_reg <= lfsr_next;
      end
   end
`endif

   // -------------------------------------------------- per-channel slices
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [PIX_W-1:0] pix_mem_reg;

      always_ff @(posedge clk) begin
         if (reset) begin
            pix_mem_reg <= '0;
         end else if (beat_accept && (ch_idx_reg == CH_W'(gi))) begin
            pix_mem_reg <= pix_data;
         end
      end

`ifdef ENC_DETERMINISTIC_EN
      // The carry out of acc + pix fires at the rate pix/2^PIX_W with no
      // randomness.
      logic [PIX_W-1:0] acc_reg;
      logic [PIX_W:0]   acc_sum;

      assign acc_sum = {1'b0, acc_reg} + {1'b0, pix_mem_reg};

      always_ff @(posedge clk) begin
         if (reset || load_done) begin
            acc_reg <= '0;
         end else if (run_tick) begin
            acc_reg <= acc_sum[PIX_W-1:0];
         end
      end

      assign spike_vec[gi] = acc_sum[PIX_W];
`else
      // Each channel sees the LFSR rotated left by (gi mod 16). This
      // decorrelates neighbouring channels without needing extra generators.
      localparam int ROT = gi % 16;
      logic [15:0] rnd;

      assign rnd = ((lfsr_reg << ROT) | (lfsr_reg >> (16 - ROT))) & RND_MASK;
      assign spike_vec[gi] = (16'(pix_mem_reg) > rnd);
`endif
   end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_encoder
//
// Self-checking bench for spike_rate_encoder with its default parameters
// (16 channels, 8-bit pixels, 32 steps). A frame table drives pixel patterns,
// tick spacing and load-time bubbles. Each strobe is compared against a
// reference model:
//   - stochastic build: a software LFSR with arithmetic rotation and compare;
//   - ENC_DETERMINISTIC_EN: the closed-form floor(t*p/256) spike schedule.
// -----------------------------------------------------------------------------
module tb_spike_rate_encoder;

   localparam int N_CH    = 16;
   localparam int PIX_W   = 8;
   localparam int N_STEPS = 32;
   localparam int SEED    = 'hACE1;
`ifdef ENC_DETERMINISTIC_EN
   localparam bit DET = 1'b1;
`else
   localparam bit DET = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              pix_valid;
   logic              pix_ready;
   logic [PIX_W-1:0]  pix_data;
   logic              tick;
   logic [N_CH-1:0]   syn;
   logic              syn_valid;
   logic              busy;
   logic              frame_done;

   spike_rate_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .tick       (tick),
      .syn        (syn),
      .syn_valid  (syn_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [PIX_W-1:0] cur_pix [N_CH];
   logic [N_CH-1:0]  hist    [N_STEPS];
   logic [N_CH-1:0]  first3  [3];
   int               cnt     [N_CH];
   int               step_idx;
   int               model_lfsr;

   typedef struct {
      int               mode;      // 0: constant fill, 1: random per channel
      logic [PIX_W-1:0] fill;
      int               gap;       // idle cycles between ticks (-1: random 0..2)
      bit               bubbles;   // random idle beats during load
      int               exp_cnt;   // expected spikes per channel, -1: model only
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Spikes for 1-based timestep t of the current frame, from the rules.
   function automatic logic [N_CH-1:0] model_spikes(input int t);
      logic [N_CH-1:0] v;
      v = '0;
      for (int i = 0; i < N_CH; i++) begin
         int p;
         int k;
         int rot;
         p = int'(cur_pix[i]);
         if (DET) begin
            v[i] = (((t * p) >> PIX_W) != (((t - 1) * p) >> PIX_W));
         end else begin
            k   = i % 16;
            rot = ((model_lfsr << k) | (model_lfsr >> (16 - k))) & 'hFFFF;
            v[i] = (p > (rot % (1 << PIX_W)));
         end
      end
      return v;
   endfunction

   function automatic int lfsr_step(input int x);
      return (x % 2 == 1) ? ((x / 2) ^ 'hB400) : (x / 2);
   endfunction

   // Loads cur_pix into the DUT; starts and ends on a negedge.
   task automatic load_frame(input bit bubbles);
      int idle;
      for (int ch = 0; ch < N_CH; ch++) begin
         idle = bubbles ? int'($urandom_range(0, 2)) : 0;
         for (int b = 0; b < idle; b++) begin
            pix_valid = 1'b0;
            pix_data  = PIX_W'($urandom);
            tick      = 1'($urandom);
            @(negedge clk);
            check("load_idle_syn_valid", 32'(syn_valid), 32'd0);
            check("load_idle_syn", 32'(syn), 32'd0);
         end
         check("load_pix_ready", 32'(pix_ready), 32'd1);
         pix_valid = 1'b1;
         pix_data  = cur_pix[ch];
         tick      = 1'($urandom);
         @(negedge clk);
         check("load_syn_valid", 32'(syn_valid), 32'd0);
      end
      pix_valid = 1'b0;
      tick      = 1'b0;
      step_idx  = 0;
      for (int i = 0; i < N_CH; i++) cnt[i] = 0;
      check("run_busy", 32'(busy), 32'd1);
      check("run_pix_ready", 32'(pix_ready), 32'd0);
   endtask

   // Issues n ticks; gap<0 picks a random spacing per tick. pix_valid is
   // held high throughout with random data, which must not be consumed.
   task automatic run_ticks(input int n, input int gap);
      logic [N_CH-1:0] exp;
      int g;
      for (int s = 0; s < n; s++) begin
         tick      = 1'b1;
         pix_valid = 1'b1;
         pix_data  = PIX_W'($urandom);
         step_idx++;
         exp = model_spikes(step_idx);
         model_lfsr = lfsr_step(model_lfsr);
         @(negedge clk);
         check("strobe_syn_valid", 32'(syn_valid), 32'd1);
         check($sformatf("strobe_syn_step%0d", step_idx), 32'(syn), 32'(exp));
         check("strobe_frame_done", 32'(frame_done), 32'(step_idx == N_STEPS));
         check("strobe_pix_ready", 32'(pix_ready), 32'(step_idx == N_STEPS));
         check("strobe_busy", 32'(busy), 32'(step_idx != N_STEPS));
         hist[step_idx - 1] = syn;
         for (int i = 0; i < N_CH; i++) cnt[i] += int'(syn[i]);
         tick = 1'b0;
         if (s < n - 1) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
               pix_valid = 1'b1;
               pix_data  = PIX_W'($urandom);
               @(negedge clk);
               check("gap_syn_valid", 32'(syn_valid), 32'd0);
               check("gap_syn", 32'(syn), 32'd0);
               check("gap_pix_ready", 32'(pix_ready), 32'd0);
            end
         end
      end
      tick      = 1'b0;
      pix_valid = 1'b0;
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{mode: 0, fill: 8'h00, gap: 0,  bubbles: 1'b0, exp_cnt: 0};
      vecs[1] = '{mode: 0, fill: 8'hFF, gap: 0,  bubbles: 1'b0, exp_cnt: DET ? 31 : -1};
      vecs[2] = '{mode: 0, fill: 8'h80, gap: 1,  bubbles: 1'b1, exp_cnt: DET ? 16 : -1};
      vecs[3] = '{mode: 0, fill: 8'h01, gap: 0,  bubbles: 1'b0, exp_cnt: DET ? 0 : -1};
      vecs[4] = '{mode: 1, fill: 8'h00, gap: -1, bubbles: 1'b1, exp_cnt: -1};
      vecs[5] = '{mode: 1, fill: 8'h00, gap: 2,  bubbles: 1'b1, exp_cnt: -1};

      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_data  = '0;
      tick      = 1'b0;
      model_lfsr = SEED;
      step_idx   = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Quiet period after reset.
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("idle_pix_ready", 32'(pix_ready), 32'd1);
         check("idle_syn", 32'(syn), 32'd0);
         check("idle_syn_valid", 32'(syn_valid), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end
      $display("idle: 20 cycles after reset");

      // Ticks in LOAD are ignored.
      for (int c = 0; c < 5; c++) begin
         tick = 1'b1;
         @(negedge clk);
         check("load_tick_syn_valid", 32'(syn_valid), 32'd0);
         check("load_tick_busy", 32'(busy), 32'd0);
      end
      tick = 1'b0;
      $display("idle: 5 ticks in LOAD");

      // Reset after 3 ticks, then reload and rerun reproduces the pattern.
      for (int i = 0; i < N_CH; i++) cur_pix[i] = PIX_W'($urandom);
      load_frame(1'b0);
      run_ticks(3, 0);
      for (int s = 0; s < 3; s++) first3[s] = hist[s];
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_pix_ready", 32'(pix_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_syn", 32'(syn), 32'd0);
      check("rst_syn_valid", 32'(syn_valid), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      model_lfsr = SEED;
      load_frame(1'b0);
      run_ticks(N_STEPS, 0);
      for (int s = 0; s < 3; s++) check($sformatf("repro_step%0d", s + 1), 32'(hist[s]), 32'(first3[s]));
      $display("reset-rerun: first steps %0h %0h %0h", hist[0], hist[1], hist[2]);

      // Table-driven frames, loaded back to back (no reset between frames).
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < N_CH; i++) begin
            cur_pix[i] = (vecs[f].mode == 0) ? vecs[f].fill : PIX_W'($urandom);
         end
         load_frame(vecs[f].bubbles);
         run_ticks(N_STEPS, vecs[f].gap);
         if (vecs[f].exp_cnt >= 0) begin
            for (int i = 0; i < N_CH; i++) begin
               check($sformatf("frame%0d_count_ch%0d", f, i), 32'(cnt[i]), 32'(vecs[f].exp_cnt));
            end
         end
         if (DET && vecs[f].fill == 8'h80 && vecs[f].mode == 0) begin
            for (int s = 0; s < N_STEPS; s++) begin
               check($sformatf("alt_step%0d", s + 1), 32'(hist[s]), (s % 2 == 1) ? 32'hFFFF : 32'h0);
            end
         end
         $display("frame %0d: mode=%0d fill=%0h gap=%0d ch0_spikes=%0d ch15_spikes=%0d",
                  f, vecs[f].mode, vecs[f].fill, vecs[f].gap, cnt[0], cnt[N_CH - 1]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
